// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen bit-field RTL.
package rggen_rtl_pkg;

  // Arbitration policy between competing hardware set channels.
  typedef enum logic {
    RGGEN_RWS_FIXED,
    RGGEN_RWS_ROUND_ROBIN
  } rggen_rws_priority_e;

endpackage

// File: rtl/rggen_bit_field_if.sv
// Connection between a register and one of its bit fields.
interface rggen_bit_field_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid, write_mask, write_data,
    input  read_data, value
  );

  modport bit_field (
    input  valid, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_rws_arbiter.sv
// One-hot arbiter for the set channels of rggen_bit_field_rws_mc.
// FIXED grants the lowest requesting index; ROUND_ROBIN starts searching one
// past the last winner and wraps.
module rggen_rws_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int                  CHANNELS      = 2,
  parameter rggen_rws_priority_e PRIORITY_MODE = RGGEN_RWS_FIXED
)(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_req,
  input  logic                i_update,
  output logic [CHANNELS-1:0] o_grant
);

  localparam int                  PTR_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CHANNELS-1:0] LSB_ONE  = CHANNELS'(1);
  localparam logic [PTR_W-1:0]    PTR_INIT = PTR_W'(CHANNELS - 1);

  logic [PTR_W-1:0]    r_ptr;
  logic [CHANNELS-1:0] w_upper_mask;
  logic [CHANNELS-1:0] w_upper_req;
  logic [CHANNELS-1:0] w_search;
  logic [PTR_W-1:0]    w_grant_idx;

  // Channels strictly above the pointer are searched first; if none of them
  // request, the search wraps to the lowest requesting index.
  assign w_upper_mask = ({CHANNELS{1'b1}} << r_ptr) << 1;
  assign w_upper_req  = i_req & w_upper_mask;
  assign w_search     = ((PRIORITY_MODE == RGGEN_RWS_ROUND_ROBIN) && (|w_upper_req))
                        ? w_upper_req : i_req;
  // Isolate the lowest set bit of the search vector.
  assign o_grant      = w_search & (~w_search + LSB_ONE);

  // Encode the one-hot grant back into a pointer value.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_grant_idx unassigned (no latch).
    w_grant_idx = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (o_grant[c]) w_grant_idx = PTR_W'(c);
    end
  end

  // Pointer follows the last winner; frozen when no grant is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!i_rst_n) begin
      r_ptr <= PTR_INIT;
    end else if (i_update && (|i_req)) begin
      r_ptr <= w_grant_idx;
    end
  end

endmodule

// File: rtl/rggen_bit_field_rws_mc.sv
// Multi-channel set/write bit field. Hardware set channels compete with each
// other and with register writes; losing set requests wait in a per-channel
// pending slot and every load from a channel is acknowledged with one pulse.
module rggen_bit_field_rws_mc
  import rggen_rtl_pkg::*;
#(
  parameter int                  WIDTH         = 8,
  parameter logic [WIDTH-1:0]    INITIAL_VALUE = '0,
  parameter int                  CHANNELS      = 2,
  parameter bit                  WRITE_FIRST   = 1'b1,
  parameter rggen_rws_priority_e PRIORITY_MODE = RGGEN_RWS_FIXED
)(
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  rggen_bit_field_if.bit_field            bit_field_if,
  input  logic [CHANNELS-1:0]             i_set,
  input  logic [CHANNELS-1:0][WIDTH-1:0]  i_value,
  output logic [CHANNELS-1:0]             o_set_ack,
  output logic [CHANNELS-1:0]             o_pending,
  output logic [WIDTH-1:0]                o_value
);

  logic [WIDTH-1:0]                r_value;
  logic [CHANNELS-1:0]             r_pending;
  logic [CHANNELS-1:0][WIDTH-1:0]  r_pend_value;
  logic [CHANNELS-1:0]             r_set_ack;

  logic                            w_write_access;
  logic [WIDTH-1:0]                w_write_value;
  logic                            w_write_wins;
  logic                            w_update;
  logic [CHANNELS-1:0]             w_req;
  logic [CHANNELS-1:0]             w_grant;
  logic [CHANNELS-1:0]             w_set_grant;
  logic [WIDTH-1:0]                w_win_value;

  assign w_write_access = bit_field_if.valid && (|bit_field_if.write_mask);
  assign w_write_value  = (bit_field_if.write_data & bit_field_if.write_mask)
                        | (r_value & ~bit_field_if.write_mask);
  assign w_req          = i_set | r_pending;

  // With WRITE_FIRST a register write blocks every set this cycle; otherwise
  // any set request wins and the write is dropped.
  assign w_write_wins   = WRITE_FIRST && w_write_access;
  assign w_update       = !w_write_wins;
  assign w_set_grant    = w_update ? w_grant : '0;

  rggen_rws_arbiter #(
    .CHANNELS      (CHANNELS),
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_arbiter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (w_req),
    .i_update (w_update),
    .o_grant  (w_grant)
  );

  // Winner's candidate: a fresh strobe carries its own value, otherwise the
  // value captured when the request went pending.
  always_comb begin
    w_win_value = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_grant[c]) w_win_value = i_set[c] ? i_value[c] : r_pend_value[c];
    end
  end

  // Field value: write-first write, else set winner, else plain write, else hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= INITIAL_VALUE;
    end else if (w_write_wins) begin
      r_value <= w_write_value;
    end else if (|w_req) begin
      r_value <= w_win_value;
    end else if (w_write_access) begin
      r_value <= w_write_value;
    end
  end

  // Pending flags and acks: every unserved request stays pending; the granted
  // channel is cleared and acked in the same edge its value lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
      r_set_ack <= '0;
    end else begin
      r_pending <= w_req & ~w_set_grant;
      r_set_ack <= w_set_grant;
    end
  end

  // Capture the latest strobed value per channel; a new strobe overwrites.
  always_ff @(posedge i_clk) begin
    // NOTE: data storage is left unreset; it is only consumed while r_pending is set.
    for (int c = 0; c < CHANNELS; c++) begin
      if (i_set[c]) r_pend_value[c] <= i_value[c];
    end
  end

  assign o_value                = r_value;
  assign o_pending              = r_pending;
  assign o_set_ack              = r_set_ack;
  assign bit_field_if.read_data = r_value;
  assign bit_field_if.value     = r_value;

endmodule
